// File: rtl/upower_pkg.sv
// Shared opcodes, field widths, FSM state type and the decoded instruction
// payload for the uPower program-counter unit.
package upower_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned LI_W     = 24;
  localparam int unsigned BD_W     = 14;
  localparam int unsigned BO_W     = 5;

  localparam logic [OPCODE_W-1:0] OPC_B  = 6'd18;
  localparam logic [OPCODE_W-1:0] OPC_BC = 6'd19;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } pc_state_t;

  // Instruction fields presented alongside the PC they belong to.
  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic                aa;
    logic                lk;
    logic [LI_W-1:0]     li;
    logic [BD_W-1:0]     bd;
    logic [BO_W-1:0]     bo;
    logic                cond_bit;
  } insn_t;

  function automatic logic is_branch(input logic [OPCODE_W-1:0] op);
    return (op == OPC_B) || (op == OPC_BC);
  endfunction

endpackage

// File: rtl/upower_branch_cond.sv
// Combinational BO evaluation for bc: CR-bit test, CTR test and the
// decremented CTR value used when the CTR is stepped.
module upower_branch_cond
  import upower_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 32,
  parameter bit          HAS_CTR  = 1'b1
) (
  input  logic [BO_W-1:0]     bo,
  input  logic                cond_bit,
  input  logic [PC_WIDTH-1:0] ctr,
  output logic                taken_cond,
  output logic [PC_WIDTH-1:0] ctr_dec
);

  logic cond_ok;
  logic ctr_ok;

  // bo[0] is a static prediction hint with no architectural effect here.
  logic unused_bo;
  assign unused_bo = bo[0];

  always_comb begin
    ctr_dec    = ctr - PC_WIDTH'(1);
    cond_ok    = bo[4] | (cond_bit == bo[3]);
    ctr_ok     = HAS_CTR ? (bo[2] | ((ctr_dec != '0) ^ bo[1])) : 1'b1;
    taken_cond = ctr_ok & cond_ok;
  end

endmodule

// File: rtl/upower_pc_unit.sv
// Word-granular program counter with b/bc resolution, LR/CTR state and a
// one-cycle fetch bubble after every taken branch.
module upower_pc_unit
  import upower_pkg::*;
#(
  parameter int unsigned         PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter bit                  HAS_CTR  = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall,
  input  logic                valid_in,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                aa,
  input  logic                lk,
  input  logic [LI_W-1:0]     li,
  input  logic [BD_W-1:0]     bd,
  input  logic [BO_W-1:0]     bo,
  input  logic                cond_bit,
  input  logic                ctr_load,
  input  logic [PC_WIDTH-1:0] ctr_wdata,
  output logic [PC_WIDTH-1:0] pc,
  output logic                pc_valid,
  output logic [PC_WIDTH-1:0] lr,
  output logic [PC_WIDTH-1:0] ctr,
  output logic                branch_taken
);

  pc_state_t           state;
  insn_t               insn;
  logic                accept;
  logic                is_b;
  logic                is_bc;
  logic                taken;
  logic                lr_wr;
  logic                ctr_dec_en;
  logic                taken_cond;
  logic [PC_WIDTH-1:0] pc_seq;
  logic [PC_WIDTH-1:0] disp;
  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] ctr_dec;

  assign insn = {opcode, aa, lk, li, bd, bo, cond_bit};

  upower_branch_cond #(
    .PC_WIDTH (PC_WIDTH),
    .HAS_CTR  (HAS_CTR)
  ) u_branch_cond (
    .bo         (insn.bo),
    .cond_bit   (insn.cond_bit),
    .ctr        (ctr),
    .taken_cond (taken_cond),
    .ctr_dec    (ctr_dec)
  );

  // Decode, target generation and acceptance qualification.
  always_comb begin
    accept     = valid_in & pc_valid & ~stall;
    is_b       = (insn.opcode == OPC_B);
    is_bc      = (insn.opcode == OPC_BC);
    pc_seq     = pc + PC_WIDTH'(1);
    disp       = is_b ? PC_WIDTH'($signed(insn.li)) : PC_WIDTH'($signed(insn.bd));
    target     = (insn.aa ? '0 : pc_seq) + disp;
    taken      = accept & (is_b | (is_bc & taken_cond));
    lr_wr      = accept & is_branch(insn.opcode) & insn.lk;
    ctr_dec_en = accept & is_bc & ~insn.bo[2];
  end

  // RUN/FLUSH sequencing together with PC, LR and the taken pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      pc           <= RESET_PC;
      pc_valid     <= 1'b1;
      lr           <= '0;
      branch_taken <= 1'b0;
    end else begin
      branch_taken <= taken;
      if (lr_wr) begin
        lr <= pc_seq;
      end
      case (state)
        RUN: begin
          if (accept) begin
            if (taken) begin
              pc       <= target;
              pc_valid <= 1'b0;
              state    <= FLUSH;
            end else begin
              pc <= pc_seq;
            end
          end
        end
        FLUSH: begin
          if (!stall) begin
            pc_valid <= 1'b1;
            state    <= RUN;
          end
        end
        default: begin
          pc_valid <= 1'b1;
          state    <= RUN;
        end
      endcase
    end
  end

  // Count register; mtctr writes are not gated by stall and beat a decrement.
  if (HAS_CTR) begin : g_ctr
    logic [PC_WIDTH-1:0] ctr_q;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        ctr_q <= '0;
      end else if (ctr_load) begin
        ctr_q <= ctr_wdata;
      end else if (ctr_dec_en) begin
        ctr_q <= ctr_dec;
      end
    end

    assign ctr = ctr_q;
  end else begin : g_no_ctr
    logic unused_ctr;
    assign unused_ctr = ^{ctr_load, ctr_wdata, ctr_dec, ctr_dec_en};
    assign ctr        = '0;
  end

endmodule

// File: doc/upower_pc_unit.md
UPOWER_PC_UNIT -- requirements
Module: upower_pc_unit

Interface
REQ-001 Parameter PC_WIDTH, default 32, width of PC, LR, CTR and all target arithmetic (minimum 24).
REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 Parameter HAS_CTR, default 1; 0 removes CTR, ctr output ties to 0, and the BO CTR test always passes.
REQ-004 clock  in  1  single clock; all state updates on posedge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 stall  in  1  freeze: no state update while high.
REQ-007 valid_in  in  1  opcode/fields describe the instruction at pc.
REQ-008 opcode  in  6  primary opcode.
REQ-009 aa, lk  in  1 each  absolute-address and link bits.
REQ-010 li  in  24  I-form displacement; bd  in  14  B-form displacement; bo  in  5  branch options.
REQ-011 cond_bit  in  1  CR bit already selected by BI.
REQ-012 ctr_load  in  1  and ctr_wdata  in  PC_WIDTH  write CTR (mtctr path).
REQ-013 pc  out  PC_WIDTH  current word address; pc_valid  out  1  pc is fetchable this cycle.
REQ-014 lr, ctr  out  PC_WIDTH  link and count registers.
REQ-015 branch_taken  out  1  registered; high one cycle after a taken branch is accepted.

Function
REQ-016 An instruction is accepted when valid_in & pc_valid & !stall.
REQ-017 PC addressing is word-granular; sequential next PC = pc + 1, modulo 2^PC_WIDTH.
REQ-018 Opcode 18 (b) is always taken; target = aa ? sext(li) : pc + 1 + sext(li).
REQ-019 Opcode 19 (bc) target = aa ? sext(bd) : pc + 1 + sext(bd); taken = ctr_ok & cond_ok.
REQ-020 cond_ok = bo[4] | (cond_bit == bo[3]).
REQ-021 ctr_ok = bo[2] | ((ctr - 1 != 0) ^ bo[1]); when bo[2]=0, CTR is decremented on acceptance whether or not the branch is taken.
REQ-022 All other opcodes advance the PC sequentially; lk and bo are ignored for them.
REQ-023 lk=1 on an accepted opcode 18/19 writes LR <= pc + 1, whether or not the branch is taken.
REQ-024 If ctr_load and a CTR decrement occur in the same cycle, ctr_load wins.
REQ-025 ctr_load is honoured even when stall is high.
REQ-026 CTR decrement from 0 wraps to all-ones.
REQ-027 Target and increment arithmetic wraps at 2^PC_WIDTH with no error flag.
REQ-028 FSM has two states, RUN and FLUSH.
REQ-029 RUN: a taken branch loads the target into pc, sets branch_taken, and moves to FLUSH.
REQ-030 FLUSH: pc_valid = 0 for exactly one unstalled cycle, then return to RUN; stall holds FLUSH.
REQ-031 In RUN, pc_valid = 1; valid_in=0 or stall=1 leaves pc unchanged.
REQ-032 branch_taken is 0 in every cycle not immediately following a taken-branch acceptance.

Reset
REQ-033 On reset assertion, asynchronously: pc=RESET_PC, lr=0, ctr=0, branch_taken=0, state=RUN (pc_valid=1 after release).
REQ-034 Reset mid-FLUSH or mid-stall discards the pending redirect; no LR/CTR update is retained from the reset cycle.

Structure
REQ-035 Package upower_pkg holds OPC_B=18, OPC_BC=19, and the pc_state_t enum {RUN, FLUSH}.
REQ-036 The BO/CR/CTR evaluation is the combinational sub-module upower_branch_cond (inputs bo, cond_bit, ctr; outputs taken_cond, ctr_dec).

Verification
REQ-037 Reset then 4 accepted non-branch instructions -> pc 0,1,2,3,4; pc_valid=1 throughout; lr=ctr=0.
REQ-038 pc=10, opcode 18, aa=0, li=-3, lk=1 -> pc=8, lr=11, branch_taken=1, pc_valid=0 for one cycle, then 1.
REQ-039 ctr_load with 2, then bc bo=5'b10000, bd=-1 at pc=20 -> first taken (ctr=1, pc=20), second not taken (ctr=0, pc=21).
REQ-040 Same cycle: ctr_load=1 with ctr_wdata=7 and bc bo[2]=0 -> ctr=7.
REQ-041 Stall high during FLUSH for 3 cycles -> pc and pc_valid=0 hold; then one cycle later pc_valid=1.
REQ-042 PC_WIDTH=24, pc=24'hFFFFFF, sequential instruction -> pc=0; reset asserted mid-FLUSH -> pc=RESET_PC immediately.
